// File: rtl/button_gesture_decoder.sv
// button_gesture_decoder: classifies a debounced button level into click/long/repeat pulses
//   clk, reset (sync, active-high)
//   enable        1=decode, 0=hold in IDLE with outputs suppressed
//   btn           debounced button level, 1=pressed
//   press_pulse / release_pulse             one-cycle edge pulses
//   single_click / double_click / long_press / repeat_pulse  one-cycle gesture pulses
//   held          level, high while in the long-press state
module button_gesture_decoder #(
   parameter int LONG_PRESS_CYCLES = 50_000_000,
   parameter int DOUBLE_GAP_CYCLES = 12_500_000,
   parameter int REPEAT_CYCLES     = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic btn,
   output logic press_pulse,
   output logic release_pulse,
   output logic single_click,
   output logic double_click,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);
   localparam int LG   = LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES ? LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
   localparam int MAXC = LG > REPEAT_CYCLES ? LG : REPEAT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] LONG_T = CW'(LONG_PRESS_CYCLES - 1);
   localparam logic [CW-1:0] GAP_T  = CW'(DOUBLE_GAP_CYCLES - 1);
   localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYCLES == 0 ? 0 : REPEAT_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic btn_prev_q;
   logic [6:0] out_q, out_d;
   logic rise, fall, sc, dc, lp, rp, reload;
   assign rise = btn & ~btn_prev_q;
   assign fall = ~btn & btn_prev_q;
   always_comb begin
      state_d = state_q;
      sc      = 1'b0;
      dc      = 1'b0;
      lp      = 1'b0;
      rp      = 1'b0;
      reload  = 1'b0;
      case (state_q)
         IDLE:    if (rise) state_d = PRESS1;
         PRESS1:  if (!btn) state_d = WAIT2;
                  else if (cnt_q == LONG_T) begin lp = 1'b1; state_d = LONG; end
         // a press on the same edge as gap expiry still counts as the second click
         WAIT2:   if (btn) state_d = PRESS2;
                  else if (cnt_q == GAP_T) begin sc = 1'b1; state_d = IDLE; end
         PRESS2:  if (!btn) begin dc = 1'b1; state_d = IDLE; end
         LONG:    if (!btn) state_d = IDLE;
                  else if (REPEAT_CYCLES != 0 && cnt_q == REP_T) begin rp = 1'b1; reload = 1'b1; end
         default: state_d = IDLE;
      endcase
      // counter idles at zero and saturates so it can never wrap
      cnt_d = (state_d != state_q || reload || state_q == IDLE) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
      out_d = {rise, fall, sc, dc, lp, rp, state_d == LONG};
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         out_d   = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         btn_prev_q <= 1'b0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         btn_prev_q <= btn;
         out_q      <= out_d;
      end
   end
   assign {press_pulse, release_pulse, single_click, double_click, long_press, repeat_pulse, held} = out_q;
endmodule

// File: tb/tb_button_gesture_decoder.sv
// tb_button_gesture_decoder: scoreboard bench for button_gesture_decoder
module tb_button_gesture_decoder;
   localparam logic [6:0] PR = 7'b1000000, RL = 7'b0100000, SC = 7'b0010000, DC = 7'b0001000;
   localparam logic [6:0] LP = 7'b0000100, RP = 7'b0000010, HD = 7'b0000001;
   typedef struct {
      int         c;
      logic [6:0] v;
   } exp_t;
   logic clk = 1'b0, reset = 1'b1, enable = 1'b1, btn = 1'b0;
   logic press_pulse, release_pulse, single_click, double_click, long_press, repeat_pulse, held;
   logic [6:0] o;
   exp_t q[$];
   int cyc = 0, total = 0, passed = 0, p;
   logic held_prev = 1'b0;
   button_gesture_decoder #(.LONG_PRESS_CYCLES(20), .DOUBLE_GAP_CYCLES(10), .REPEAT_CYCLES(5)) dut (
      .clk(clk), .reset(reset), .enable(enable), .btn(btn),
      .press_pulse(press_pulse), .release_pulse(release_pulse), .single_click(single_click),
      .double_click(double_click), .long_press(long_press), .repeat_pulse(repeat_pulse), .held(held)
   );
   assign o = {press_pulse, release_pulse, single_click, double_click, long_press, repeat_pulse, held};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (o[6:1] != 6'd0 || o[0] != held_prev) begin
         total++;
         if (q.size() == 0)
            $display("FAIL event: unexpected outputs %b at cycle %0d, none required", o, cyc);
         else begin
            exp_t e;
            e = q.pop_front();
            if (e.c == cyc && e.v == o) passed++;
            else $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d", o, cyc, e.v, e.c);
         end
      end
      held_prev = o[0];
   end
   task automatic expect_ev(input int c, input logic [6:0] v);
      exp_t e;
      e.c = c;
      e.v = v;
      q.push_back(e);
   endtask
   task automatic drive(input logic b, input int n);
      btn = b;
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check_zero(input string name);
      total++;
      if (o == 7'd0) passed++;
      else $display("FAIL %s: outputs %b, required 0000000", name, o);
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      reset = 1'b0;
      drive(0, 3);
      // single click
      p = cyc + 1;
      expect_ev(p, PR); expect_ev(p + 5, RL); expect_ev(p + 15, SC);
      drive(1, 5); drive(0, 25);
      // double click
      p = cyc + 1;
      expect_ev(p, PR); expect_ev(p + 5, RL); expect_ev(p + 9, PR); expect_ev(p + 12, RL | DC);
      drive(1, 5); drive(0, 4); drive(1, 3); drive(0, 20);
      // long press with auto-repeat
      p = cyc + 1;
      expect_ev(p, PR); expect_ev(p + 20, LP | HD); expect_ev(p + 25, RP | HD);
      expect_ev(p + 30, RP | HD); expect_ev(p + 35, RP | HD); expect_ev(p + 40, RL);
      drive(1, 40); drive(0, 20);
      // second press exactly at gap expiry
      p = cyc + 1;
      expect_ev(p, PR); expect_ev(p + 5, RL); expect_ev(p + 15, PR); expect_ev(p + 18, RL | DC);
      drive(1, 5); drive(0, 10); drive(1, 3); drive(0, 20);
      // second press one cycle after gap expiry
      p = cyc + 1;
      expect_ev(p, PR); expect_ev(p + 5, RL); expect_ev(p + 15, SC); expect_ev(p + 16, PR);
      expect_ev(p + 19, RL); expect_ev(p + 29, SC);
      drive(1, 5); drive(0, 11); drive(1, 3); drive(0, 20);
      // reset while held
      p = cyc + 1;
      expect_ev(p, PR); expect_ev(p + 14, PR); expect_ev(p + 34, LP | HD); expect_ev(p + 36, RL);
      drive(1, 12);
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         check_zero("during_reset");
      end
      reset = 1'b0;
      drive(1, 22); drive(0, 20);
      // disabled activity, then re-enable while held
      enable = 1'b0;
      drive(1, 5); drive(0, 5); drive(1, 2);
      enable = 1'b1;
      drive(1, 30);
      p = cyc + 1;
      expect_ev(p, RL);
      drive(0, 5);
      p = cyc + 1;
      expect_ev(p, PR); expect_ev(p + 3, RL); expect_ev(p + 13, SC);
      drive(1, 3); drive(0, 20);
      total++;
      if (q.size() == 0) passed++;
      else $display("FAIL leftover: %0d events never seen, required 0 (next at cycle %0d)", q.size(), q[0].c);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end
endmodule
